decode_stage: RTL and testbench



---
 rtl/riscv_pkg.sv | 59 +++++
 rtl/reg_file.sv | 27 ++
 rtl/decode_stage.sv | 130 +++++++++++++
 tb/tb_decode_stage.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared opcode, control encodings and ID/EX register layout
package riscv_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [1:0] ALU_OP_ADD = 2'b00;
   localparam logic [1:0] ALU_OP_BR  = 2'b01;
   localparam logic [1:0] ALU_OP_R   = 2'b10;
   localparam logic [1:0] ALU_OP_I   = 2'b11;

   localparam logic [1:0] WB_SEL_ALU = 2'b00;
   localparam logic [1:0] WB_SEL_MEM = 2'b01;
   localparam logic [1:0] WB_SEL_PC4 = 2'b10;

   localparam logic [1:0] SRC_A_RS1  = 2'b00;
   localparam logic [1:0] SRC_A_PC   = 2'b01;
   localparam logic [1:0] SRC_A_ZERO = 2'b10;

   typedef struct packed {
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       branch;
      logic       jal;
      logic       jalr;
      logic       alu_src_b;
      logic [1:0] alu_src_a;
      logic [1:0] alu_op;
      logic [1:0] wb_sel;
      logic       illegal;
   } ctrl_t;

   localparam ctrl_t CTRL_BUBBLE = '0;

   typedef struct packed {
      logic [31:0] rs1_data;
      logic [31:0] rs2_data;
      logic [31:0] imm;
      logic [31:0] pc;
      logic [31:0] pc_incr4;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [2:0]  funct3;
      logic        funct7b5;
      ctrl_t       ctrl;
   } idex_t;

   localparam idex_t IDEX_BUBBLE = '0;

endpackage

// File: rtl/reg_file.sv
// reg_file: 2-read 1-write integer register file, x0 zero, write-through bypass
module reg_file #(
   parameter int XLEN = 32,
   parameter int NREG = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [$clog2(NREG)-1:0] rs1,
   input  logic [$clog2(NREG)-1:0] rs2,
   input  logic                    wb_en,
   input  logic [$clog2(NREG)-1:0] wb_rd,
   input  logic [XLEN-1:0]         wb_data,
   output logic [XLEN-1:0]         rs1_data,
   output logic [XLEN-1:0]         rs2_data
);

   logic [XLEN-1:0] regs [NREG];

   // store WB results; x0 is never written so it stays zero
   always_ff @(posedge clk or negedge rst)
      if (!rst) regs <= '{default: '0};
      else if (wb_en && wb_rd != '0) regs[wb_rd] <= wb_data;

   assign rs1_data = (rs1 == '0) ? '0 : (wb_en && wb_rd == rs1) ? wb_data : regs[rs1];
   assign rs2_data = (rs2 == '0) ? '0 : (wb_en && wb_rd == rs2) ? wb_data : regs[rs2];

endmodule

// File: rtl/decode_stage.sv
// decode_stage: ID stage with register file, decode, load-use stall and ID/EX register
module decode_stage
   import riscv_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int NREG = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [31:0]     inst_in,
   input  logic [XLEN-1:0] pc_in,
   input  logic [XLEN-1:0] pc_incr4_in,
   input  logic            flush,
   input  logic            wb_en,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_data,
   input  logic            ex_mem_read,
   input  logic [4:0]      ex_rd,
   output logic            stall,
   output logic [XLEN-1:0] rs1_data_out,
   output logic [XLEN-1:0] rs2_data_out,
   output logic [XLEN-1:0] imm_out,
   output logic [XLEN-1:0] pc_out,
   output logic [XLEN-1:0] pc_incr4_out,
   output logic [4:0]      rs1_out,
   output logic [4:0]      rs2_out,
   output logic [4:0]      rd_out,
   output logic [2:0]      funct3_out,
   output logic            funct7b5_out,
   output logic            reg_write_out,
   output logic            mem_read_out,
   output logic            mem_write_out,
   output logic            branch_out,
   output logic            jal_out,
   output logic            jalr_out,
   output logic            alu_src_b_out,
   output logic [1:0]      alu_src_a_out,
   output logic [1:0]      alu_op_out,
   output logic [1:0]      wb_sel_out,
   output logic            illegal_out
);

   logic [6:0]      opcode;
   logic [4:0]      rs1, rs2, rd;
   logic [XLEN-1:0] rs1_data, rs2_data;
   logic [31:0]     imm, imm_i, imm_s, imm_b, imm_j, imm_u;
   logic            use_rs1, use_rs2;
   ctrl_t           c;
   idex_t           dec, q;

   assign opcode = inst_in[6:0];
   assign rd     = inst_in[11:7];
   assign rs1    = inst_in[19:15];
   assign rs2    = inst_in[24:20];

   assign imm_i = {{20{inst_in[31]}}, inst_in[31:20]};
   assign imm_s = {{20{inst_in[31]}}, inst_in[31:25], inst_in[11:7]};
   assign imm_b = {{19{inst_in[31]}}, inst_in[31], inst_in[7], inst_in[30:25], inst_in[11:8], 1'b0};
   assign imm_j = {{11{inst_in[31]}}, inst_in[31], inst_in[19:12], inst_in[20], inst_in[30:21], 1'b0};
   assign imm_u = {inst_in[31:12], 12'b0};

   reg_file #(.XLEN(XLEN), .NREG(NREG)) u_rf (
      .clk      (clk),
      .rst      (rst),
      .rs1      (rs1),
      .rs2      (rs2),
      .wb_en    (wb_en),
      .wb_rd    (wb_rd),
      .wb_data  (wb_data),
      .rs1_data (rs1_data),
      .rs2_data (rs2_data)
   );

   // opcode decode: controls, immediate select and which source registers are real
   always_comb begin
      c       = CTRL_BUBBLE;
      imm     = '0;
      use_rs1 = 1'b1;
      use_rs2 = 1'b0;
      case (opcode)
         OP_R: begin
            c.reg_write = 1'b1; c.alu_op = ALU_OP_R; use_rs2 = 1'b1;
         end
         OP_I: begin
            c.reg_write = 1'b1; c.alu_op = ALU_OP_I; c.alu_src_b = 1'b1; imm = imm_i;
         end
         OP_LOAD: begin
            c.reg_write = 1'b1; c.mem_read = 1'b1; c.alu_src_b = 1'b1; c.wb_sel = WB_SEL_MEM; imm = imm_i;
         end
         OP_STORE: begin
            c.mem_write = 1'b1; c.alu_src_b = 1'b1; imm = imm_s; use_rs2 = 1'b1;
         end
         OP_BRANCH: begin
            c.branch = 1'b1; c.alu_op = ALU_OP_BR; imm = imm_b; use_rs2 = 1'b1;
         end
         OP_JAL: begin
            c.reg_write = 1'b1; c.jal = 1'b1; c.alu_src_a = SRC_A_PC; c.alu_src_b = 1'b1;
            c.wb_sel = WB_SEL_PC4; imm = imm_j; use_rs1 = 1'b0;
         end
         OP_JALR: begin
            c.reg_write = 1'b1; c.jalr = 1'b1; c.alu_src_b = 1'b1; c.wb_sel = WB_SEL_PC4; imm = imm_i;
         end
         OP_LUI: begin
            c.reg_write = 1'b1; c.alu_src_a = SRC_A_ZERO; c.alu_src_b = 1'b1; imm = imm_u; use_rs1 = 1'b0;
         end
         OP_AUIPC: begin
            c.reg_write = 1'b1; c.alu_src_a = SRC_A_PC; c.alu_src_b = 1'b1; imm = imm_u; use_rs1 = 1'b0;
         end
         default: begin
            c.illegal = 1'b1; use_rs1 = 1'b0;
         end
      endcase
   end

   assign stall = ex_mem_read && ex_rd != '0 &&
                  ((use_rs1 && ex_rd == rs1) || (use_rs2 && ex_rd == rs2));

   assign dec = {rs1_data, rs2_data, imm, pc_in, pc_incr4_in, rs1, rs2, rd,
                 inst_in[14:12], inst_in[30], c};

   // ID/EX register: bubble on flush or load-use stall, otherwise take decoded values
   always_ff @(posedge clk or negedge rst)
      if (!rst) q <= IDEX_BUBBLE;
      else q <= (flush || stall) ? IDEX_BUBBLE : dec;

   assign {rs1_data_out, rs2_data_out, imm_out, pc_out, pc_incr4_out, rs1_out, rs2_out, rd_out,
           funct3_out, funct7b5_out, reg_write_out, mem_read_out, mem_write_out, branch_out,
           jal_out, jalr_out, alu_src_b_out, alu_src_a_out, alu_op_out, wb_sel_out, illegal_out} = q;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed vectors with a scoreboard queue checked by a separate monitor
module tb_decode_stage;

   typedef struct packed {
      logic [31:0] d1, d2, imm, pc, pc4;
      logic [4:0]  rs1, rs2, rd;
      logic [2:0]  f3;
      logic        f7, rw, mr, mw, br, jal, jalr, sb;
      logic [1:0]  sa, aop, ws;
      logic        ill;
   } exp_t;

   logic        clk = 1'b0, rst = 1'b0;
   logic [31:0] inst_in = '0, pc_in = '0, pc_incr4_in = '0, wb_data = '0;
   logic        flush = 1'b0, wb_en = 1'b0, ex_mem_read = 1'b0;
   logic [4:0]  wb_rd = '0, ex_rd = '0;
   logic        stall;
   logic [31:0] rs1_data_out, rs2_data_out, imm_out, pc_out, pc_incr4_out;
   logic [4:0]  rs1_out, rs2_out, rd_out;
   logic [2:0]  funct3_out;
   logic        funct7b5_out, reg_write_out, mem_read_out, mem_write_out, branch_out;
   logic        jal_out, jalr_out, alu_src_b_out, illegal_out;
   logic [1:0]  alu_src_a_out, alu_op_out, wb_sel_out;
   exp_t        act, e;
   exp_t        sq[$];
   string       nq[$];
   int          checks = 0, failures = 0;

   always #5 clk = ~clk;

   decode_stage dut (
      .clk(clk), .rst(rst), .inst_in(inst_in), .pc_in(pc_in), .pc_incr4_in(pc_incr4_in),
      .flush(flush), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
      .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .stall(stall),
      .rs1_data_out(rs1_data_out), .rs2_data_out(rs2_data_out), .imm_out(imm_out),
      .pc_out(pc_out), .pc_incr4_out(pc_incr4_out), .rs1_out(rs1_out), .rs2_out(rs2_out),
      .rd_out(rd_out), .funct3_out(funct3_out), .funct7b5_out(funct7b5_out),
      .reg_write_out(reg_write_out), .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
      .branch_out(branch_out), .jal_out(jal_out), .jalr_out(jalr_out),
      .alu_src_b_out(alu_src_b_out), .alu_src_a_out(alu_src_a_out), .alu_op_out(alu_op_out),
      .wb_sel_out(wb_sel_out), .illegal_out(illegal_out)
   );

   assign act = {rs1_data_out, rs2_data_out, imm_out, pc_out, pc_incr4_out, rs1_out, rs2_out,
                 rd_out, funct3_out, funct7b5_out, reg_write_out, mem_read_out, mem_write_out,
                 branch_out, jal_out, jalr_out, alu_src_b_out, alu_src_a_out, alu_op_out,
                 wb_sel_out, illegal_out};

   function automatic exp_t ex(logic [31:0] p, logic [4:0] r1, logic [4:0] r2, logic [4:0] rd,
                               logic [2:0] f3, logic f7, logic [31:0] imm,
                               logic [31:0] d1, logic [31:0] d2);
      exp_t r = '0;
      r.pc = p; r.pc4 = p + 32'd4; r.rs1 = r1; r.rs2 = r2; r.rd = rd;
      r.f3 = f3; r.f7 = f7; r.imm = imm; r.d1 = d1; r.d2 = d2;
      return r;
   endfunction

   task automatic step(string name, logic [31:0] i, logic [31:0] p, logic we, logic [4:0] wr,
                       logic [31:0] wd, logic fl, logic emr, logic [4:0] erd, logic es, exp_t x);
      @(negedge clk);
      inst_in = i; pc_in = p; pc_incr4_in = p + 32'd4;
      wb_en = we; wb_rd = wr; wb_data = wd; flush = fl; ex_mem_read = emr; ex_rd = erd;
      #1;
      checks++;
      if (stall !== es) begin
         failures++;
         $display("FAIL %s_stall: got %0b want %0b", name, stall, es);
      end
      sq.push_back(x);
      nq.push_back(name);
      @(posedge clk);
   endtask

   initial begin : monitor
      exp_t  x;
      string n;
      forever begin
         @(posedge clk);
         #1;
         if (sq.size() != 0) begin
            x = sq.pop_front();
            n = nq.pop_front();
            checks++;
            if (act !== x) begin
               failures++;
               $display("FAIL %s: got %h want %h", n, act, x);
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : stim
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (act !== '0 || stall !== 1'b0) begin
         failures++;
         $display("FAIL reset: got %h stall %0b want 0", act, stall);
      end
      @(negedge clk);
      rst = 1'b1;

      e = ex(32'h100, 5, 0, 0, 0, 0, 0, 0, 0); e.rw = 1; e.aop = 2'b11; e.sb = 1;
      step("read_x5_zero", 32'h00028013, 32'h100, 0, 0, 0, 0, 0, 0, 0, e);

      e = ex(32'h104, 5, 0, 6, 0, 0, 0, 32'hDEADBEEF, 0); e.rw = 1; e.aop = 2'b10;
      step("add_bypass", 32'h00028333, 32'h104, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, e);

      e = ex(32'h108, 5, 0, 6, 0, 0, 0, 32'hDEADBEEF, 0); e.rw = 1; e.aop = 2'b10;
      step("add_stored", 32'h00028333, 32'h108, 0, 0, 0, 0, 0, 0, 0, e);

      e = ex(32'h10C, 0, 0, 6, 0, 0, 0, 0, 0); e.rw = 1; e.aop = 2'b10;
      step("x0_write", 32'h00000333, 32'h10C, 1, 0, 32'h1234, 0, 0, 0, 0, e);
      e.pc = 32'h110; e.pc4 = 32'h114;
      step("x0_read", 32'h00000333, 32'h110, 0, 0, 0, 0, 0, 0, 0, e);

      step("load_use_rs1", 32'h00128393, 32'h114, 0, 0, 0, 0, 1, 5, 1, '0);
      e = ex(32'h114, 5, 1, 7, 0, 0, 1, 32'hDEADBEEF, 0); e.rw = 1; e.aop = 2'b11; e.sb = 1;
      step("no_stall_rd0", 32'h00128393, 32'h114, 0, 0, 0, 0, 1, 0, 0, e);

      step("load_use_rs2", 32'h00500333, 32'h118, 0, 0, 0, 0, 1, 5, 1, '0);

      e = ex(32'h11C, 0, 0, 25, 0, 1, 32'hFFFFFFF8, 0, 0); e.br = 1; e.aop = 2'b01;
      step("beq", 32'hFE000CE3, 32'h11C, 0, 0, 0, 0, 0, 0, 0, e);

      e = ex(32'h120, 8, 3, 1, 5, 0, 32'h12345000, 0, 0); e.rw = 1; e.sa = 2'b10; e.sb = 1;
      step("lui_nostall", 32'h123450B7, 32'h120, 0, 0, 0, 0, 1, 8, 0, e);

      e = ex(32'h124, 0, 8, 1, 0, 0, 32'h8, 0, 0);
      e.rw = 1; e.jal = 1; e.sa = 2'b01; e.sb = 1; e.ws = 2'b10;
      step("jal_nostall", 32'h008000EF, 32'h124, 0, 0, 0, 0, 1, 8, 0, e);

      step("flush_sw", 32'h00112223, 32'h128, 0, 0, 0, 1, 0, 0, 0, '0);
      e = ex(32'h12C, 2, 1, 4, 2, 0, 32'h4, 0, 0); e.mw = 1; e.sb = 1;
      step("sw", 32'h00112223, 32'h12C, 0, 0, 0, 0, 0, 0, 0, e);

      e = ex(32'h130, 5, 28, 9, 2, 1, 32'hFFFFFFFC, 32'hDEADBEEF, 0);
      e.rw = 1; e.mr = 1; e.sb = 1; e.ws = 2'b01;
      step("lw", 32'hFFC2A483, 32'h130, 0, 0, 0, 0, 0, 0, 0, e);

      e = ex(32'h134, 0, 0, 0, 0, 0, 0, 0, 0); e.ill = 1;
      step("illegal", 32'h0000007F, 32'h134, 0, 0, 0, 0, 0, 0, 0, e);

      step("flush_and_stall", 32'h00128393, 32'h138, 0, 0, 0, 1, 1, 5, 1, '0);

      e = ex(32'h13C, 5, 0, 1, 0, 0, 0, 32'hDEADBEEF, 0);
      e.rw = 1; e.jalr = 1; e.sb = 1; e.ws = 2'b10;
      step("jalr", 32'h000280E7, 32'h13C, 0, 0, 0, 0, 0, 0, 0, e);

      @(negedge clk);
      wb_en = 1'b0; flush = 1'b0; ex_mem_read = 1'b0;
      rst = 1'b0;
      #1;
      checks++;
      if (act !== '0) begin
         failures++;
         $display("FAIL midop_reset: got %h want 0", act);
      end
      @(negedge clk);
      rst = 1'b1;

      e = ex(32'h200, 5, 0, 0, 0, 0, 0, 0, 0); e.rw = 1; e.aop = 2'b11; e.sb = 1;
      step("x5_after_reset", 32'h00028013, 32'h200, 0, 0, 0, 0, 0, 0, 0, e);

      repeat (3) @(posedge clk);
      #2;
      if (sq.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL drain: got %0d pending want 0", sq.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
